muldiv_unit: RTL and testbench

Iterative multiply/divide unit holding the architectural HI and LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the register-file read ports in the Harvard datapath and takes the same rs/rt operands the ALU receives. It produces HI/LO for MFHI/MFLO through the result path, plus a busy flag the controller uses to stall the PC via `clk_enable`.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // LO value written by a divide with a zero divisor.
  localparam logic [31:0] MULDIV_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add on {acc, multiplier}; bit_o is the bit shifted into the
// top of the multiplier register.
// Divide: restoring shift-subtract; mq_bit_i is the next dividend bit and
// bit_o is the new quotient bit.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic             mq_bit_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             bit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Both candidate results are formed; div_i picks one.
  always_comb begin
    sum     = {1'b0, acc_i} + (mq_bit_i ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, mq_bit_i};
    // True difference is below the divisor whenever it is used, so the
    // low WIDTH bits of a modular subtract are exact.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    if (div_i) begin
      if (shifted >= {1'b0, opnd_i}) begin
        acc_o = diff;
        bit_o = 1'b1;
      end else begin
        acc_o = shifted[WIDTH-1:0];
        bit_o = 1'b0;
      end
    end else begin
      acc_o = sum[WIDTH:1];
      bit_o = sum[0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN: multiplies are computed in one cycle with
// a full-width multiplier instead of the WIDTH-step shift-add loop.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // partial product high half / remainder
  logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic             div_q, div_d;
  logic             neg_q, neg_d;     // negate product or quotient
  logic             rneg_q, rneg_d;   // negate remainder (sign of a)
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q;

  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_acc;
  logic             step_bit;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mq_bit_i (div_q ? mq_q[WIDTH-1] : mq_q[0]),
    .opnd_i   (opnd_q),
    .div_i    (div_q),
    .acc_o    (step_acc),
    .bit_o    (step_bit)
  );

  // Operand magnitudes and signs; the core always works on unsigned values.
  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    sa     = sgn_op & a[WIDTH-1];
    sb     = sgn_op & b[WIDTH-1];
    abs_a  = sa ? -a : a;
    abs_b  = sb ? -b : b;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod_raw = {acc_q, mq_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = neg_q ? -mq_q : mq_q;
    rem_fix  = rneg_q ? -acc_q : acc_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (muldiv_op_t'(op))
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
              div_d  = 1'b0;
              div0_d = 1'b0;
              neg_d  = sa ^ sb;
              rneg_d = 1'b0;
              cnt_d  = '0;
`ifdef MULDIV_FAST_MUL_EN
              {acc_d, mq_d} = fast_prod;
              state_d = ST_FIX;
`else
              acc_d   = '0;
              mq_d    = abs_b;
              opnd_d  = abs_a;
              state_d = ST_RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              div_d  = 1'b1;
              neg_d  = sa ^ sb;
              rneg_d = sa;
              cnt_d  = '0;
              if (b == '0) begin
                // Keep the raw dividend so HI returns it unmodified.
                div0_d  = 1'b1;
                acc_d   = a;
                state_d = ST_FIX;
              end else begin
                div0_d  = 1'b0;
                acc_d   = '0;
                mq_d    = abs_a;
                opnd_d  = abs_b;
                state_d = ST_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        mq_d  = div_q ? {mq_q[WIDTH-2:0], step_bit} : {step_bit, mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          hi_d = acc_q;
          lo_d = WIDTH'(MULDIV_DIV0_LO);
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything holds while clk_enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [31:0] hi_m, lo_m;
  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .op(op), .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO after the op, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin u = {32'h0, x} * {32'h0, y}; hi_m = u[63:32]; lo_m = u[31:0]; end
      3'd2: begin
        if (y == 0) begin hi_m = x; lo_m = 32'hFFFF_FFFF; end
        else begin p = sx / sy; lo_m = p[31:0]; p = sx % sy; hi_m = p[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin hi_m = x; lo_m = 32'hFFFF_FFFF; end
        else begin lo_m = x / y; hi_m = x % y; end
      end
      3'd4: hi_m = x;
      3'd5: lo_m = x;
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] y);
    int l;
    l = 33;
    if (o[1] && y == 0) l = 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) l = 1;
`endif
    return l;
  endfunction

  // Drive one start at E0; operands are scrambled afterwards so a DUT that
  // fails to latch them is exposed.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Counts edges until done; edges in [g_lo, g_hi) run with clk_enable low.
  task automatic wait_done(input int g_lo, input int g_hi, output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      clk_enable = !(cyc >= g_lo && cyc < g_hi);
      @(posedge clk); #1;
      cyc++;
    end
    clk_enable = 1'b1;
    if (cyc >= 200) chk("done_timeout", done, 1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int cyc;
    launch(o, x, y);
    chk("done_pulse_end", done, 0);
    if (o >= 3'd4) begin
      chk("busy_idle_op", busy, 0);
      chk("hi", hi, hi_m);
      chk("lo", lo, lo_m);
    end else begin
      chk("busy_start", busy, 1);
      wait_done(0, 0, cyc);
      chk("latency", cyc, exp_lat(o, y));
      chk("hi", hi, hi_m);
      chk("lo", lo, lo_m);
      chk("busy_end", busy, 0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 100);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk) reset = 1'b0;

    do_op(3'd4, 32'hDEAD_BEEF, 32'h0);           // MTHI
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // MULTU
    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0005);   // MULT -1*5
    do_op(3'd2, -32'sd7, 32'd2);                 // DIV -7/2
    do_op(3'd3, 32'h0000_1234, 32'h0);           // DIVU by zero
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);   // DIV overflow wrap
    do_op(3'd2, 32'h8000_0000, 32'h0);           // DIV by zero, negative a
    do_op(3'd6, 32'h1111_1111, 32'h2);           // reserved

    // MTLO while a DIVU is running must be dropped.
    launch(3'd3, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 0, cyc);
    chk("mtlo_busy_latency", cyc + 10, 33);
    chk("mtlo_busy_lo", lo, lo_m);
    chk("mtlo_busy_hi", hi, hi_m);

    // clk_enable low for 5 edges mid-RUN stretches latency by 5.
    launch(3'd3, 32'd100, 32'd7);
    wait_done(10, 15, cyc);
    chk("stall_latency", cyc, 38);
    chk("stall_lo", lo, 14);
    chk("stall_hi", hi, 2);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    // Asynchronous reset in the middle of a MULTU.
    do_op(3'd4, 32'hA5A5_A5A5, 32'h0);
    do_op(3'd5, 32'h5A5A_5A5A, 32'h0);
    launch(3'd1, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    hi_m = '0; lo_m = '0;
    @(negedge clk) reset = 1'b0;
    do_op(3'd3, 32'd9, 32'd3);
    chk("post_rst_lo", lo, 3);
    chk("post_rst_hi", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
